// File: rtl/axi_perf_pkg.sv
// Shared widths, statistics record and saturating arithmetic for the AXI
// performance counter.
package axi_perf_pkg;

  localparam int DEF_DATA_WIDTH    = 64;
  localparam int DEF_CNT_WIDTH     = 32;
  localparam int DEF_OT_WIDTH      = 8;
  localparam int DEF_WINDOW_CYCLES = 1024;

  // Widest counter sat_add can serve; narrower counters are zero-extended in.
  localparam int SAT_MAX_WIDTH = 64;

  // Per-direction statistics record at the default widths.
  typedef struct packed {
    logic [DEF_CNT_WIDTH-1:0] txn;
    logic [DEF_CNT_WIDTH-1:0] bytes;
    logic [DEF_CNT_WIDTH-1:0] lat_sum;
    logic [DEF_OT_WIDTH-1:0]  ot_max;
  } dir_stats_t;

  // a + b clipped to the all-ones value of a w-bit counter.
  function automatic logic [SAT_MAX_WIDTH-1:0] sat_add(
    input logic [SAT_MAX_WIDTH-1:0] a,
    input logic [SAT_MAX_WIDTH-1:0] b,
    input int unsigned              w
  );
    logic [SAT_MAX_WIDTH:0] sum;
    logic [SAT_MAX_WIDTH:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = ((SAT_MAX_WIDTH+1)'(1) << w) - (SAT_MAX_WIDTH+1)'(1);
    return (sum > lim) ? lim[SAT_MAX_WIDTH-1:0] : sum[SAT_MAX_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/axi_perf_counter_if.sv
// Handshake signals of one observed AXI port. A beat transfers on a rising
// ACLK edge where VALID and READY are both high; neither side may infer a
// transfer from VALID or READY alone.
interface axi_perf_counter_if #(
  parameter int DATA_WIDTH = 64
);

  logic                    AWVALID;
  logic                    AWREADY;
  logic                    WVALID;
  logic                    WREADY;
  logic                    WLAST;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    BVALID;
  logic                    BREADY;
  logic                    ARVALID;
  logic                    ARREADY;
  logic                    RVALID;
  logic                    RREADY;
  logic                    RLAST;

  modport master (
    output AWVALID, AWREADY, WVALID, WREADY, WLAST, WSTRB, BVALID, BREADY,
    output ARVALID, ARREADY, RVALID, RREADY, RLAST
  );

  modport slave (
    input AWVALID, AWREADY, WVALID, WREADY, WLAST, WSTRB, BVALID, BREADY,
    input ARVALID, ARREADY, RVALID, RREADY, RLAST
  );

endinterface

// File: rtl/axi_perf_dir.sv
// One direction of the performance counter: outstanding-transaction tracking,
// orphan-completion detection and the live/snapshot statistics registers.
module axi_perf_dir
  import axi_perf_pkg::*;
#(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int OT_WIDTH  = DEF_OT_WIDTH,
  parameter int BYTE_W    = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 window_end_i,
  input  logic                 start_i,
  input  logic                 end_i,
  input  logic [BYTE_W-1:0]    bytes_i,
  output logic [CNT_WIDTH-1:0] snap_txn_o,
  output logic [CNT_WIDTH-1:0] snap_bytes_o,
  output logic [CNT_WIDTH-1:0] snap_lat_sum_o,
  output logic [OT_WIDTH-1:0]  snap_ot_max_o,
  output logic                 ot_err_o
);

  typedef struct packed {
    logic [CNT_WIDTH-1:0] txn;
    logic [CNT_WIDTH-1:0] bytes;
    logic [CNT_WIDTH-1:0] lat_sum;
    logic [OT_WIDTH-1:0]  ot_max;
  } stats_t;

  logic [OT_WIDTH-1:0] ot_q, ot_d;
  logic                err_q, err_d;
  stats_t              live_q, live_d;
  stats_t              snap_q, snap_d;
  stats_t              upd;
  logic                no_ot;
  logic                orphan_end;
  logic                valid_end;

  always_comb begin
    no_ot      = (ot_q == '0);
    // A completion with nothing in flight is dropped, unless a start in the
    // same cycle pairs with it.
    orphan_end = end_i && !start_i && no_ot;
    valid_end  = end_i && !orphan_end;

    ot_d = ot_q;
    if (start_i && !end_i) begin
      if (ot_q != '1) ot_d = ot_q + 1'b1;
    end else if (end_i && !start_i && !no_ot) begin
      ot_d = ot_q - 1'b1;
    end

    err_d = err_q | orphan_end;

    upd = live_q;
    if (en_i) begin
      upd.txn     = CNT_WIDTH'(sat_add(64'(live_q.txn), 64'(valid_end), CNT_WIDTH));
      upd.bytes   = CNT_WIDTH'(sat_add(64'(live_q.bytes), 64'(bytes_i), CNT_WIDTH));
      upd.lat_sum = CNT_WIDTH'(sat_add(64'(live_q.lat_sum), 64'(ot_q), CNT_WIDTH));
      upd.ot_max  = (ot_d > live_q.ot_max) ? ot_d : live_q.ot_max;
    end

    live_d = upd;
    snap_d = snap_q;
    if (window_end_i) begin
      snap_d        = upd;
      live_d        = '0;
      live_d.ot_max = ot_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ot_q   <= '0;
      err_q  <= 1'b0;
      live_q <= '0;
      snap_q <= '0;
    end else begin
      ot_q   <= ot_d;
      err_q  <= err_d;
      live_q <= live_d;
      snap_q <= snap_d;
    end
  end

  assign snap_txn_o     = snap_q.txn;
  assign snap_bytes_o   = snap_q.bytes;
  assign snap_lat_sum_o = snap_q.lat_sum;
  assign snap_ot_max_o  = snap_q.ot_max;
  assign ot_err_o       = err_q;

endmodule

// File: rtl/axi_perf_counter.sv
// Passive AXI performance counter: derives per-direction start/end/byte events
// from the bus, runs the sample window and publishes a snapshot per window.
module axi_perf_counter
  import axi_perf_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH     = DEF_CNT_WIDTH,
  parameter int OT_WIDTH      = DEF_OT_WIDTH,
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic                 en,
  axi_perf_counter_if.slave    bus,
  output logic                 snap_valid,
  output logic [CNT_WIDTH-1:0] rd_txn,
  output logic [CNT_WIDTH-1:0] wr_txn,
  output logic [CNT_WIDTH-1:0] rd_bytes,
  output logic [CNT_WIDTH-1:0] wr_bytes,
  output logic [CNT_WIDTH-1:0] rd_lat_sum,
  output logic [CNT_WIDTH-1:0] wr_lat_sum,
  output logic [OT_WIDTH-1:0]  rd_ot_max,
  output logic [OT_WIDTH-1:0]  wr_ot_max,
  output logic                 ot_err
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int BYTE_W = $clog2(STRB_W) + 1;
  localparam int WIN_W  = $clog2(WINDOW_CYCLES);

  function automatic logic [BYTE_W-1:0] popcount(input logic [STRB_W-1:0] s);
    logic [BYTE_W-1:0] c;
    c = '0;
    for (int i = 0; i < STRB_W; i++) c = c + BYTE_W'(s[i]);
    return c;
  endfunction

  logic              rd_start, rd_end, r_beat;
  logic              wr_start, wr_end, w_beat;
  logic [BYTE_W-1:0] rd_bytes_inc, wr_bytes_inc;
  logic [WIN_W-1:0]  win_q, win_d;
  logic              window_end;
  logic              snap_valid_q;
  logic              rd_err, wr_err;
  logic              unused_wlast;

  // WLAST carries no information here: W bytes count per beat and a write
  // completes on its B response.
  assign unused_wlast = bus.WLAST;

  always_comb begin
    rd_start     = bus.ARVALID && bus.ARREADY;
    r_beat       = bus.RVALID && bus.RREADY;
    rd_end       = r_beat && bus.RLAST;
    rd_bytes_inc = r_beat ? BYTE_W'(STRB_W) : '0;

    wr_start     = bus.AWVALID && bus.AWREADY;
    w_beat       = bus.WVALID && bus.WREADY;
    wr_end       = bus.BVALID && bus.BREADY;
    wr_bytes_inc = w_beat ? popcount(bus.WSTRB) : '0;
  end

  // The window only advances on enabled cycles, so a disabled stretch
  // pushes the window end out by exactly that many cycles.
  always_comb begin
    window_end = en && (win_q == WIN_W'(WINDOW_CYCLES - 1));
    win_d      = win_q;
    if (en) win_d = window_end ? '0 : win_q + 1'b1;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      win_q        <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      win_q        <= win_d;
      snap_valid_q <= window_end;
    end
  end

  axi_perf_dir #(
    .CNT_WIDTH (CNT_WIDTH),
    .OT_WIDTH  (OT_WIDTH),
    .BYTE_W    (BYTE_W)
  ) u_rd (
    .clk_i          (ACLK),
    .rst_i          (ARESET),
    .en_i           (en),
    .window_end_i   (window_end),
    .start_i        (rd_start),
    .end_i          (rd_end),
    .bytes_i        (rd_bytes_inc),
    .snap_txn_o     (rd_txn),
    .snap_bytes_o   (rd_bytes),
    .snap_lat_sum_o (rd_lat_sum),
    .snap_ot_max_o  (rd_ot_max),
    .ot_err_o       (rd_err)
  );

  axi_perf_dir #(
    .CNT_WIDTH (CNT_WIDTH),
    .OT_WIDTH  (OT_WIDTH),
    .BYTE_W    (BYTE_W)
  ) u_wr (
    .clk_i          (ACLK),
    .rst_i          (ARESET),
    .en_i           (en),
    .window_end_i   (window_end),
    .start_i        (wr_start),
    .end_i          (wr_end),
    .bytes_i        (wr_bytes_inc),
    .snap_txn_o     (wr_txn),
    .snap_bytes_o   (wr_bytes),
    .snap_lat_sum_o (wr_lat_sum),
    .snap_ot_max_o  (wr_ot_max),
    .ot_err_o       (wr_err)
  );

  assign snap_valid = snap_valid_q;
  assign ot_err     = rd_err | wr_err;

endmodule

// File: tb/tb_axi_perf_counter.sv
// Directed bench for axi_perf_counter: a cycle-indexed bus schedule drives the
// port, hand-computed window snapshots are queued and checked as they appear.
module tb_axi_perf_counter;

  localparam int DW   = 64;
  localparam int CW   = 32;
  localparam int OW   = 8;
  localparam int WIN  = 100;
  localparam int NCYC = 600;

  typedef struct packed {
    logic [15:0]   cyc;
    logic [CW-1:0] rd_txn;
    logic [CW-1:0] rd_bytes;
    logic [CW-1:0] rd_lat;
    logic [OW-1:0] rd_max;
    logic [CW-1:0] wr_txn;
    logic [CW-1:0] wr_bytes;
    logic [CW-1:0] wr_lat;
    logic [OW-1:0] wr_max;
    logic          err;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  // ---------------- clock / reset ----------------
  logic ACLK   = 1'b0;
  logic ARESET = 1'b1;
  logic en     = 1'b1;
  always #5 ACLK = ~ACLK;

  int   pos_cnt = 0;
  int   base    = 0;
  logic rst_seen = 1'b1;
  always @(posedge ACLK) begin
    pos_cnt  <= pos_cnt + 1;
    rst_seen <= ARESET;
  end

  // ---------------- DUTs ----------------
  axi_perf_counter_if #(.DATA_WIDTH(DW)) bus ();

  logic          snap_valid, ot_err;
  logic [CW-1:0] rd_txn, wr_txn, rd_bytes, wr_bytes, rd_lat_sum, wr_lat_sum;
  logic [OW-1:0] rd_ot_max, wr_ot_max;

  axi_perf_counter #(
    .DATA_WIDTH(DW), .CNT_WIDTH(CW), .OT_WIDTH(OW), .WINDOW_CYCLES(WIN)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .en(en), .bus(bus),
    .snap_valid(snap_valid),
    .rd_txn(rd_txn), .wr_txn(wr_txn),
    .rd_bytes(rd_bytes), .wr_bytes(wr_bytes),
    .rd_lat_sum(rd_lat_sum), .wr_lat_sum(wr_lat_sum),
    .rd_ot_max(rd_ot_max), .wr_ot_max(wr_ot_max),
    .ot_err(ot_err)
  );

  logic       s8_valid, s8_err;
  logic [7:0] s8_rd_txn, s8_wr_txn, s8_rd_bytes, s8_wr_bytes, s8_rd_lat, s8_wr_lat;
  logic [7:0] s8_rd_max, s8_wr_max;

  axi_perf_counter #(
    .DATA_WIDTH(DW), .CNT_WIDTH(8), .OT_WIDTH(OW), .WINDOW_CYCLES(WIN)
  ) dut8 (
    .ACLK(ACLK), .ARESET(ARESET), .en(en), .bus(bus),
    .snap_valid(s8_valid),
    .rd_txn(s8_rd_txn), .wr_txn(s8_wr_txn),
    .rd_bytes(s8_rd_bytes), .wr_bytes(s8_wr_bytes),
    .rd_lat_sum(s8_rd_lat), .wr_lat_sum(s8_wr_lat),
    .rd_ot_max(s8_rd_max), .wr_ot_max(s8_wr_max),
    .ot_err(s8_err)
  );

  // ---------------- schedule ----------------
  bit         ar_s[NCYC], r_s[NCYC], rl_s[NCYC];
  bit         aw_s[NCYC], w_s[NCYC], b_s[NCYC];
  bit         rst_s[NCYC], en_off[NCYC];
  logic [7:0] ws_s[NCYC];

  task automatic rbeat(input int t, input bit last);
    r_s[t]  = 1'b1;
    rl_s[t] = last;
  endtask

  task automatic wbeat(input int t, input logic [7:0] strb);
    w_s[t]  = 1'b1;
    ws_s[t] = strb;
  endtask

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  logic [15:0]      exp8_q[$];
  int total = 0;
  int bad   = 0;

  task automatic push_exp(input int cyc, input int rt, input int rb, input int rl,
                          input int rm, input int wt, input int wb, input int wl,
                          input int wm, input bit err);
    exp_t e;
    e.cyc = 16'(cyc);
    e.rd_txn = CW'(rt); e.rd_bytes = CW'(rb); e.rd_lat = CW'(rl); e.rd_max = OW'(rm);
    e.wr_txn = CW'(wt); e.wr_bytes = CW'(wb); e.wr_lat = CW'(wl); e.wr_max = OW'(wm);
    e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  function automatic logic [1:0] pair(input bit fire);
    logic c;
    if (fire) return 2'b11;
    c = 1'($urandom_range(0, 1));
    return {c, ~c};
  endfunction

  task automatic drive(input int t);
    ARESET = rst_s[t];
    en     = !en_off[t];
    {bus.ARVALID, bus.ARREADY} = pair(ar_s[t]);
    {bus.RVALID,  bus.RREADY}  = pair(r_s[t]);
    bus.RLAST = r_s[t] ? rl_s[t] : 1'($urandom_range(0, 1));
    {bus.AWVALID, bus.AWREADY} = pair(aw_s[t]);
    {bus.WVALID,  bus.WREADY}  = pair(w_s[t]);
    bus.WSTRB = w_s[t] ? ws_s[t] : 8'($urandom);
    bus.WLAST = 1'($urandom_range(0, 1));
    {bus.BVALID,  bus.BREADY}  = pair(b_s[t]);
  endtask

  initial begin
    // window 0: single read, one write, read straddling into window 1
    aw_s[5] = 1; wbeat(6, 8'h0F); wbeat(7, 8'h0F); b_s[12] = 1;
    ar_s[10] = 1;
    for (int t = 17; t <= 20; t++) rbeat(t, t == 20);
    ar_s[90] = 1;
    push_exp(100, 1, 32, 19, 1, 1, 8, 7, 1, 0);
    exp8_q.push_back({8'd1, 8'd32});

    // window 1: straddle end, three overlapping reads, start+end together
    rbeat(110, 1);
    ar_s[120] = 1; ar_s[121] = 1; ar_s[122] = 1;
    rbeat(140, 1); rbeat(141, 1); rbeat(142, 1);
    ar_s[160] = 1; ar_s[170] = 1; rbeat(170, 1); rbeat(180, 1);
    push_exp(200, 6, 48, 91, 3, 0, 0, 0, 0, 0);
    exp8_q.push_back({8'd6, 8'd48});

    // window 2: orphan B, unaddressed W beats, 40 R beats (saturates 8-bit)
    b_s[210] = 1;
    wbeat(220, 8'hFF); wbeat(221, 8'h81);
    for (int t = 230; t < 270; t++) rbeat(t, 0);
    push_exp(300, 0, 320, 0, 0, 0, 10, 0, 0, 1);
    exp8_q.push_back({8'd0, 8'd255});

    // window 3: en low for 50 cycles, read completes while frozen
    for (int t = 320; t < 370; t++) en_off[t] = 1;
    ar_s[310] = 1; rbeat(330, 1);
    push_exp(450, 0, 0, 9, 1, 0, 0, 0, 0, 1);
    exp8_q.push_back({8'd0, 8'd0});

    // window 4: read in flight then reset mid-window; fresh window from 483
    ar_s[460] = 1;
    for (int t = 480; t <= 482; t++) rst_s[t] = 1;
    push_exp(583, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp8_q.push_back({8'd0, 8'd0});

    ARESET = 1'b1;
    drive(0);
    ARESET = 1'b1;
    repeat (3) @(negedge ACLK);
    base = pos_cnt;
    for (int t = 0; t < NCYC; t++) begin
      if (t > 0) @(negedge ACLK);
      drive(t);
    end
    repeat (3) @(negedge ACLK);
    check("exp_q_drained", 256'(exp_q.size()), 256'(0));
    check("exp8_q_drained", 256'(exp8_q.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- monitors ----------------
  logic [207:0] last_snap = '0;
  logic [207:0] cur;
  exp_t         e;

  always @(negedge ACLK) begin
    if (pos_cnt >= 1) begin
      cur = {rd_txn, rd_bytes, rd_lat_sum, rd_ot_max, wr_txn, wr_bytes, wr_lat_sum, wr_ot_max};
      if (rst_seen) begin
        last_snap = '0;
        check("reset_zero", {snap_valid, ot_err, cur}, 256'(0));
      end else if (snap_valid) begin
        check("snap_expected", 256'(exp_q.size() != 0), 256'(1));
        if (exp_q.size() != 0) begin
          e = exp_t'(exp_q.pop_front());
          check("snap_cycle", 256'(pos_cnt - base), 256'(e.cyc));
          check("rd_txn", rd_txn, e.rd_txn);
          check("rd_bytes", rd_bytes, e.rd_bytes);
          check("rd_lat_sum", rd_lat_sum, e.rd_lat);
          check("rd_ot_max", rd_ot_max, e.rd_max);
          check("wr_txn", wr_txn, e.wr_txn);
          check("wr_bytes", wr_bytes, e.wr_bytes);
          check("wr_lat_sum", wr_lat_sum, e.wr_lat);
          check("wr_ot_max", wr_ot_max, e.wr_max);
          check("ot_err", ot_err, e.err);
          last_snap = {e.rd_txn, e.rd_bytes, e.rd_lat, e.rd_max,
                       e.wr_txn, e.wr_bytes, e.wr_lat, e.wr_max};
        end
      end else begin
        check("snap_hold", cur, last_snap);
      end
    end
  end

  logic [15:0] e8;
  always @(negedge ACLK) begin
    if (pos_cnt >= 1 && !rst_seen && s8_valid) begin
      check("snap8_expected", 256'(exp8_q.size() != 0), 256'(1));
      if (exp8_q.size() != 0) begin
        e8 = exp8_q.pop_front();
        check("rd_txn_w8", s8_rd_txn, e8[15:8]);
        check("rd_bytes_sat_w8", s8_rd_bytes, e8[7:0]);
      end
    end
  end

endmodule

// File: doc/axi_perf_counter.md
# axi_perf_counter

Synthesizable, passive AXI performance counter attached to one AXI port. It observes the handshakes on all five channels and keeps windowed counts per direction: completed transactions, bytes, accumulated latency and peak outstanding transactions. It publishes a snapshot once per programmable window. It extends the team's logging bus monitors into hardware that can be read at runtime and used in silicon and emulation, where text logs are not available.

## Interface
Parameters:
- DATA_WIDTH, 64, AXI data width in bits; must be a power of two, 8 to 1024.
- CNT_WIDTH, 32, width of every statistic counter.
- OT_WIDTH, 8, width of the outstanding-transaction counters.
- WINDOW_CYCLES, 1024, sample window length in enabled cycles; must be at least 2.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  reset; synchronous, active-high.
- en  in  1  1 = window counter and statistics advance; 0 = both freeze.
- AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY  in  1 each  write-side handshakes.
- WSTRB  in  DATA_WIDTH/8  write strobes.
- ARVALID, ARREADY, RVALID, RREADY, RLAST  in  1 each  read-side handshakes.
- snap_valid  out  1  one-cycle pulse: all snapshot outputs updated.
- rd_txn, wr_txn  out  CNT_WIDTH  transactions completed in the window.
- rd_bytes, wr_bytes  out  CNT_WIDTH  bytes moved in the window.
- rd_lat_sum, wr_lat_sum  out  CNT_WIDTH  sum over window cycles of the outstanding count.
- rd_ot_max, wr_ot_max  out  OT_WIDTH  peak outstanding count in the window.
- ot_err  out  1  sticky; a completion arrived with no transaction outstanding.

## Operation
- Handshake: valid && ready, sampled at the ACLK rising edge. The block drives nothing onto the bus.
- Read start: AR handshake. Read end: R handshake with RLAST. Write start: AW handshake. Write end: B handshake. W beats are counted independently of AW ordering.
- Outstanding count (rd_ot / wr_ot):
  - +1 on start, −1 on end; start and end in the same cycle leave it unchanged.
  - It updates even when en=0, so it stays consistent with the bus.
  - It saturates at 2^OT_WIDTH−1.
- End when ot==0 and no simultaneous start: set ot_err, hold ot at 0, do not count the transaction.
- Statistics update only when en=1:
  - txn += 1 per valid end.
  - rd_bytes += DATA_WIDTH/8 per R handshake.
  - wr_bytes += popcount(WSTRB) per W handshake.
  - lat_sum += registered ot value each cycle. Per Little's law, each transaction contributes (end cycle − start cycle).
  - ot_max = max(ot_max, next ot).
- All statistic counters saturate at all-ones and never wrap.
- Window counter runs 0..WINDOW_CYCLES−1, advancing only when en=1.
- Window end (counter at its last value and en=1):
  - Snapshot registers take live values including that cycle's events.
  - Live counters clear to 0. ot_max reloads with the next ot.
  - Outstanding counts are not cleared; a transaction that straddles the window boundary splits its latency across windows and counts as a txn in the window where it ends.

## Timing
- Reset value of every output is 0, ot_err included. ARESET also clears the window counter, outstanding counts and all live counters. A reset in mid-window discards partial statistics, and no snapshot is produced.
- snap_valid asserts in the cycle after the window-end cycle. Snapshot outputs change only in that same cycle and otherwise hold.
- If en=0 in the window-end cycle, the window does not end; it ends on the next enabled cycle.
- ot_err clears only on ARESET.

## Structure
- Package axi_perf_pkg holds:
  - default widths;
  - a sat_add function (counter + increment, saturating);
  - a dir_stats_t struct {txn, bytes, lat_sum, ot_max}.
- Sub-module axi_perf_dir is instantiated twice, once per direction.
  - It contains the ot counter, ot_err logic and the live and snapshot dir_stats_t registers.
  - Inputs: start, end, byte increment, en, window_end.
- The top level holds the window counter, the strobe popcount and the snap_valid register.

## Test plan
Defaults DATA_WIDTH=64 and WINDOW_CYCLES=100. Cycle 0 is the first cycle with ARESET low; en=1 unless stated.
- Single read: AR at cycle 10, 4 R beats, RLAST at cycle 20 -> snap_valid at cycle 100; rd_txn=1, rd_bytes=32, rd_lat_sum=10, rd_ot_max=1.
- Write: AW at 5, W beats at 6 and 7 with WSTRB=0x0F, B at 12 -> wr_txn=1, wr_bytes=8, wr_lat_sum=7.
- Three overlapping reads: AR at 10/11/12, RLAST at 30/31/32 -> rd_ot_max=3, rd_lat_sum=60. A simultaneous AR and RLAST at 40/50 leaves ot unchanged.
- Straddle: AR at 90, RLAST at 110 -> window 0: rd_txn=0, rd_lat_sum=9. Window 1: rd_txn=1, rd_lat_sum=11, rd_ot_max=1.
- Error and en:
  - B handshake with wr_ot=0 -> ot_err=1 and stays 1; wr_txn=0.
  - en=0 for 50 cycles -> next snap_valid slips by 50 cycles.
- Saturation with CNT_WIDTH=8: 40 R beats in one window -> rd_bytes=255, not 64.
